// File: rtl/pipe_cond_sum_adder_if.sv
// Handshake and operand/result bundle for the pipelined conditional-sum adder.
interface pipe_cond_sum_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_cond_sum_adder.sv
// Pipelined conditional-sum adder/subtractor: one SEG-bit segment is resolved per
// stage, with the inter-segment carry, pending operands and finished sum bits registered.

// One segment: sums and carry-out for both possible carry-ins, built by doubling.
module pcsa_seg #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] s0,
    output logic [SEG-1:0] s1,
    output logic           c0,
    output logic           c1
);
    localparam int LVL = $clog2(SEG);

    always_comb begin
        // p*: per-bit sum assuming block carry-in 0/1; k*: carry-out of the block holding the bit
        logic [SEG-1:0] p0, p1, k0, k1, n0, n1, m0, m1;
        p0 = a ^ b;
        p1 = ~(a ^ b);
        k0 = a & b;
        k1 = a | b;
        for (int l = 0; l < LVL; l++) begin
            n0 = p0;
            n1 = p1;
            m0 = k0;
            m1 = k1;
            for (int j = 0; j < SEG; j++) begin
                int lo, mid;
                lo  = (j >> (l + 1)) << (l + 1);
                mid = lo + (1 << l);
                if (j >= mid) begin
                    n0[j] = k0[lo] ? p1[j] : p0[j];
                    n1[j] = k1[lo] ? p1[j] : p0[j];
                end
                if (mid < SEG) begin
                    m0[j] = k0[lo] ? k1[mid] : k0[mid];
                    m1[j] = k1[lo] ? k1[mid] : k0[mid];
                end else begin
                    m0[j] = k0[lo];
                    m1[j] = k1[lo];
                end
            end
            p0 = n0;
            p1 = n1;
            k0 = m0;
            k1 = m1;
        end
        s0 = p0;
        s1 = p1;
        c0 = k0[0];
        c1 = k1[0];
    end
endmodule

module pipe_cond_sum_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_cond_sum_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || SEG < 2) begin : g_bad_param
        $error("pipe_cond_sum_adder: WIDTH must be a multiple of SEG and SEG >= 2");
    end

    logic              en;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   cy;
    logic              ovf_q;

    // Single global enable: the whole pipe advances or the whole pipe holds.
    assign en          = ~vld_pipe[STAGES] | bus.out_ready;
    assign bus.in_ready = en;
    assign vld_pipe[0] = bus.in_valid;
    assign cy[0]       = bus.cin | bus.sub;

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        localparam int LO = i * SEG;
        localparam int UW = WIDTH - LO;

        logic [UW-1:0]     a_in, b_in;
        logic [SEG-1:0]    s0, s1, seg_sum;
        logic              c0, c1, c_out;
        logic [LO+SEG-1:0] sum_d, sum_q;
        logic              vld_q, cy_q;

        if (i == 0) begin : g_first
            assign a_in  = bus.a;
            assign b_in  = bus.b ^ {WIDTH{bus.sub}};
            assign sum_d = seg_sum;
        end else begin : g_next
            assign a_in  = g_st[i-1].g_fwd.a_q;
            assign b_in  = g_st[i-1].g_fwd.b_q;
            assign sum_d = {seg_sum, g_st[i-1].sum_q};
        end

        pcsa_seg #(.SEG(SEG)) u_seg (
            .a  (a_in[SEG-1:0]),
            .b  (b_in[SEG-1:0]),
            .s0 (s0),
            .s1 (s1),
            .c0 (c0),
            .c1 (c1)
        );

        assign seg_sum = cy[i] ? s1 : s0;
        assign c_out   = cy[i] ? c1 : c0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                vld_q <= vld_pipe[i];
                cy_q  <= c_out;
                sum_q <= sum_d;
            end
        end

        assign vld_pipe[i+1] = vld_q;
        assign cy[i+1]       = cy_q;

        // Only the segments still unresolved travel on to later stages.
        if (i < STAGES - 1) begin : g_fwd
            logic [UW-SEG-1:0] a_q, b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[UW-1:SEG];
                    b_q <= b_in[UW-1:SEG];
                end
            end
        end else begin : g_last
            logic cmsb;
            // Carry into the MSB recovered from the resolved sum bit and its operand bits.
            assign cmsb = seg_sum[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     ovf_q <= 1'b0;
                else if (en) ovf_q <= cmsb ^ c_out;
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = g_st[STAGES-1].sum_q;
    assign bus.cout      = cy[STAGES];
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipe_cond_sum_adder.md
# pipe_cond_sum_adder

Parametrised, pipelined conditional-sum adder/subtractor; the next generation of the team's fixed-width combinational conditional-sum adders. Operands are split into SEG-bit segments, one segment is resolved per pipeline stage, and inter-segment carries travel in pipeline registers. The block accepts one operation per cycle under a valid/ready handshake and supports full backpressure. It sits in datapaths that need 64-bit or wider add/sub at high clock rates, where a single-cycle carry chain does not close timing.

## Interface
- WIDTH, 64: operand and result width in bits.
- SEG, 16: segment width, one segment per stage. WIDTH % SEG must be 0 and SEG >= 2; otherwise elaboration fails with $error.
- Derived: STAGES = WIDTH/SEG, the pipeline depth and latency in cycles.

- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  the operation on a/b/cin/sub is valid.
- in_ready  out  1  the block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a+~b+1, i.e. a-b.
- out_valid  out  1  sum, cout and ovf hold a result.
- out_ready  in  1  the downstream consumer takes the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out of the MSB. For sub it is 1 when there is no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow: the carry into the MSB XOR the carry out of it.

## Operation
- Each segment i (0..STAGES-1) computes the SEG-bit sums for carry-in 0 and for carry-in 1 using conditional-sum doubling. The actual incoming carry then selects one of the two.
- Stage i resolves segment i. Segment 0 uses the effective carry-in: cin, or 1 when sub=1.
- Operand segments not yet resolved are carried forward in stage registers, with ~b already applied when sub=1.
- Resolved sum segments are also carried forward in stage registers, so result bits stay aligned.
- Each stage's outgoing carry is registered into the next stage.
- The last stage produces cout. ovf is taken from the last segment's carry into its MSB and carry out of its MSB.
- Stall rule, global: en = ~out_valid | out_ready, and in_ready = en.
  - When en=0, every stage register and valid bit holds its value.
  - When en=1, all stages shift by one position.
- An operation is accepted on an edge where in_valid & in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters the pipe.
- A result is consumed on an edge where out_valid & out_ready.
- While out_valid=0, sum/cout/ovf hold the last value written into the final stage. No requirement applies to them beyond reset values.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, all internal valid bits 0. in_ready=1 whenever rst=0 and out_valid=0.
- Latency: an operation accepted at edge k is presented with out_valid=1 after edge k+STAGES-1, given no stalls. With STAGES=1 the result appears after the accept edge itself.
- Throughput: one operation per cycle while out_ready=1. Back-to-back accepts produce back-to-back results.
- Stall: out_valid=1 with out_ready=0 freezes the whole pipe, including in_ready=0, in the same cycle. No operation is lost or duplicated.
- Simultaneous events: consuming the output and accepting a new input on the same edge is legal and is the steady state.
- Reset mid-operation: asserting rst clears all in-flight operations immediately, without waiting for a clock edge. After rst is released, no stale result appears.
- in_ready is a combinational function of out_valid and out_ready. There is no combinational path from in_valid or the operands to any output.

## Test plan
All scenarios use WIDTH=64 and SEG=16 (STAGES=4) unless stated otherwise.
- Basic add: a=2, b=5, cin=0 accepted at edge 0 -> out_valid rises after edge 3 with sum=7, cout=0, ovf=0. Also a=128, b=128, cin=1 -> sum=257.
- Carry across all segments: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0. Also a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0. Also a=25623210, b=222340, sub=1 -> sum=25400870, cout=1.
- Throughput and backpressure:
  - Send 8 back-to-back ops, each a=i, b=i, with out_ready=1 -> results 0,2,…,14 on 8 consecutive cycles.
  - Repeat with out_ready=0 for cycles 5-7 -> in_ready=0 during those cycles, the outputs hold, and the same 8 results arrive in order with none dropped or repeated.
- Reset mid-flight: accept 3 ops, then pulse rst between clock edges -> out_valid=0 and sum=0 immediately, and no result appears in the following 10 cycles.
- Parameter sweep, against a reference model for 1000 random ops each:
  - WIDTH=32, SEG=8 -> latency 4.
  - WIDTH=64, SEG=64 -> latency 1.
  - WIDTH=128, SEG=32 -> latency 4.
